mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single main-memory port between two cache management units: the instruction-side CMU (port prefix i_) and the data-side CMU (port prefix d_).
- The arbiter grants the memory port to one requester at a time and holds that grant for the whole transaction (write-back plus fill, chip-select held continuously).
- It forwards the winner's cs/we/addr/data to memory and routes mem_ack_i/mem_data_i back to the winner only.
- It sits between the two CMUs and the memory model. Per-requester ack counters are provided for debug.

Parameters:
- ADDR_WIDTH, 32, memory address width.
- DATA_WIDTH, 32, memory data width.
- CNT_WIDTH, 16, width of each debug ack counter.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous reset, active-low: state resets when rst==0 at posedge.
- i_cs_i  input  1  I-side request (chip select).
- i_we_i  input  1  I-side write enable.
- i_addr_i  input  ADDR_WIDTH  I-side address.
- i_data_i  input  DATA_WIDTH  I-side write data.
- i_data_o  output  DATA_WIDTH  read data to I-side.
- i_ack_o  output  1  ack to I-side.
- d_cs_i, d_we_i, d_addr_i, d_data_i, d_data_o, d_ack_o: same as the I-side ports, for the D-side.
- mem_cs_o  output  1  memory chip select.
- mem_we_o  output  1  memory write enable.
- mem_addr_o  output  ADDR_WIDTH  memory address.
- mem_data_o  output  DATA_WIDTH  memory write data.
- mem_data_i  input  DATA_WIDTH  memory read data.
- mem_ack_i  input  1  memory word-complete ack.
- grant_o  output  2  current grant, one-hot: bit0 = I, bit1 = D, 00 = none.
- i_ack_cnt_o  output  CNT_WIDTH  count of acks delivered to the I-side.
- d_ack_cnt_o  output  CNT_WIDTH  count of acks delivered to the D-side.

Behaviour:
- Reset (rst==0 at posedge):
  - state=IDLE, grant_o=00, both counters=0, last_winner=I.
  - While rst==0, mem_cs_o, mem_we_o, i_ack_o and d_ack_o are forced 0 combinationally.
- States: IDLE, GNT_I, GNT_D. The state is registered; all output muxing is combinational from the registered state.
- IDLE:
  - mem_cs_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0; both acks 0.
  - Only I requesting -> GNT_I. Only D requesting -> GNT_D.
  - Both requesting -> GNT_D (fixed priority; see the optional feature).
  - Neither requesting -> stay in IDLE.
- GNT_x:
  - mem_cs_o, mem_we_o, mem_addr_o and mem_data_o equal the x-side inputs.
  - x_ack_o = mem_ack_i; the other side's ack is 0.
  - Both i_data_o and d_data_o carry mem_data_i at all times; requesters qualify the data with their own ack.
- Release: in GNT_x, x_cs_i==0 at a posedge -> IDLE, and last_winner=x.
  - The grant is never pre-empted while x_cs_i stays high, regardless of the other request or the number of acks.
- Latency and turnaround:
  - A request seen in IDLE is granted at the next posedge, so first forwarding is 1 cycle after the request.
  - After a release there is always at least one IDLE cycle with mem_cs_o=0 before the next grant.
- If mem_ack_i is high while the state is IDLE, it is ignored: routed nowhere and not counted.
- Counters:
  - x_ack_cnt_o increments on each posedge where state==GNT_x and mem_ack_i==1.
  - Counters saturate at all-ones; there is no wrap.
- Reset mid-grant: the grant is dropped and the state goes to IDLE on that edge. Counters clear. No ack is delivered afterwards.
- A requester whose cs is high while the other side holds the grant simply waits (it sees ack=0). Its inputs are not sampled.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: when both request in IDLE, the side not equal to last_winner wins (round-robin). last_winner resets to I, so the first tie goes to D.
- Undefined: D always wins ties (fixed priority). last_winner is still maintained but unused.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1, no requests -> grant_o=00, mem_cs_o=0, both counters 0.
- Single I burst:
  - Stimulus: i_cs_i=1, i_we_i=0, i_addr_i=0x0000_1000; memory acks 4 words (one every 2 cycles); then i_cs_i drops.
  - Response: grant_o=01 one cycle after the request; mem_addr_o tracks i_addr_i; i_ack_o pulses 4 times; d_ack_o=0 throughout; i_ack_cnt_o=4; state returns to IDLE.
- Simultaneous requests, fixed priority: i_cs_i and d_cs_i rise in the same cycle.
  - D is granted first, with 4 acks.
  - After D releases: one IDLE cycle with mem_cs_o=0, then grant_o=01.
  - Final i_ack_cnt_o=4 and d_ack_cnt_o=4.
- Round-robin (MEM_ARB_RR_EN defined): three back-to-back tie rounds -> grant order D, I, D, I, D, I.
- No pre-emption:
  - Stimulus: D holds cs for 8 acks (write-back plus fill) while i_cs_i=1 the whole time.
  - Response: grant_o stays 10 for all 8 acks; i_ack_o=0; I is granted only after d_cs_i drops.
- Reset mid-grant:
  - Stimulus: rst=0 after 2 of 4 acks in GNT_I.
  - Response: next cycle grant_o=00, mem_cs_o=0, i_ack_cnt_o=0. A stray mem_ack_i during the following IDLE is not forwarded.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester main-memory arbiter (I-side CMU, D-side CMU) with whole-transaction grants.
// Optional MEM_ARB_RR_EN: ties in IDLE alternate via last_winner instead of always favouring D.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cs_i,
  input  logic                  i_we_i,
  input  logic [ADDR_WIDTH-1:0] i_addr_i,
  input  logic [DATA_WIDTH-1:0] i_data_i,
  output logic [DATA_WIDTH-1:0] i_data_o,
  output logic                  i_ack_o,
  input  logic                  d_cs_i,
  input  logic                  d_we_i,
  input  logic [ADDR_WIDTH-1:0] d_addr_i,
  input  logic [DATA_WIDTH-1:0] d_data_i,
  output logic [DATA_WIDTH-1:0] d_data_o,
  output logic                  d_ack_o,
  output logic                  mem_cs_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic                  mem_ack_i,
  output logic [1:0]            grant_o,
  output logic [CNT_WIDTH-1:0]  i_ack_cnt_o,
  output logic [CNT_WIDTH-1:0]  d_ack_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t               state_q;
  logic                 last_d_q;   // 1 = D won the most recent grant
  logic [CNT_WIDTH-1:0] i_cnt_q;
  logic [CNT_WIDTH-1:0] d_cnt_q;
  logic                 tie_pick_d;

`ifdef MEM_ARB_RR_EN
  assign tie_pick_d = ~last_d_q;
`else
  // Fixed priority: D always wins a tie; last_winner is tracked but has no effect.
  assign tie_pick_d = 1'b1 | last_d_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      i_cnt_q  <= '0;
      d_cnt_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_cs_i && d_cs_i) state_q <= tie_pick_d ? GNT_D : GNT_I;
          else if (d_cs_i)      state_q <= GNT_D;
          else if (i_cs_i)      state_q <= GNT_I;
        end
        GNT_I: begin
          if (mem_ack_i && !(&i_cnt_q)) i_cnt_q <= i_cnt_q + CNT_WIDTH'(1);
          if (!i_cs_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
          end
        end
        GNT_D: begin
          if (mem_ack_i && !(&d_cnt_q)) d_cnt_q <= d_cnt_q + CNT_WIDTH'(1);
          if (!d_cs_i) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_cs_o   = 1'b0;
    mem_we_o   = 1'b0;
    mem_addr_o = '0;
    mem_data_o = '0;
    i_ack_o    = 1'b0;
    d_ack_o    = 1'b0;
    case (state_q)
      GNT_I: begin
        mem_cs_o   = i_cs_i;
        mem_we_o   = i_we_i;
        mem_addr_o = i_addr_i;
        mem_data_o = i_data_i;
        i_ack_o    = mem_ack_i;
      end
      GNT_D: begin
        mem_cs_o   = d_cs_i;
        mem_we_o   = d_we_i;
        mem_addr_o = d_addr_i;
        mem_data_o = d_data_i;
        d_ack_o    = mem_ack_i;
      end
      default: ;
    endcase
    // Strobes are gated by reset level, not just by the registered state.
    if (!rst) begin
      mem_cs_o = 1'b0;
      mem_we_o = 1'b0;
      i_ack_o  = 1'b0;
      d_ack_o  = 1'b0;
    end
  end

  assign grant_o     = {state_q == GNT_D, state_q == GNT_I};
  assign i_data_o    = mem_data_i;
  assign d_data_o    = mem_data_i;
  assign i_ack_cnt_o = i_cnt_q;
  assign d_ack_cnt_o = d_cnt_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized + directed bench for mem_arbiter against a per-cycle behavioural model.
// Narrow counters (3 bits) so that saturation is reached.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int CW  = 3;
  localparam int SAT = (1 << CW) - 1;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic i_cs, i_we, d_cs, d_we, mem_ack;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_wdata, d_wdata, mem_rdata;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic i_ack, d_ack, mem_cs, mem_we;
  logic [AW-1:0] mem_addr;
  logic [1:0] grant;
  logic [CW-1:0] i_cnt, d_cnt;

  int checks = 0;
  int errors = 0;

  // Model: grant owner 0=none 1=I 2=D, last winner 0=I 1=D, ack counts.
  int mg, lw, ci, cd;
  bit started = 1'b0;
  logic [1:0] prev_grant = 2'b00;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .i_cs_i(i_cs), .i_we_i(i_we), .i_addr_i(i_addr), .i_data_i(i_wdata),
    .i_data_o(i_rdata), .i_ack_o(i_ack),
    .d_cs_i(d_cs), .d_we_i(d_we), .d_addr_i(d_addr), .d_data_i(d_wdata),
    .d_data_o(d_rdata), .d_ack_o(d_ack),
    .mem_cs_o(mem_cs), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .grant_o(grant), .i_ack_cnt_o(i_cnt), .d_ack_cnt_o(d_cnt)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!rst) begin
      mg <= 0; lw <= 0; ci <= 0; cd <= 0; started <= 1'b1;
    end else if (mg == 0) begin
      if (i_cs && d_cs)  mg <= (RR && lw == 1) ? 1 : 2;
      else if (d_cs)     mg <= 2;
      else if (i_cs)     mg <= 1;
    end else if (mg == 1) begin
      if (mem_ack && ci < SAT) ci <= ci + 1;
      if (!i_cs) begin mg <= 0; lw <= 0; end
    end else begin
      if (mem_ack && cd < SAT) cd <= cd + 1;
      if (!d_cs) begin mg <= 0; lw <= 1; end
    end
  end

  always @(negedge clk) begin
    logic ecs, ewe, eia, eda;
    logic [AW-1:0] eaddr;
    logic [DW-1:0] edata;
    logic [1:0] eg;
    if (started) begin
      ecs = 1'b0; ewe = 1'b0; eia = 1'b0; eda = 1'b0; eaddr = '0; edata = '0; eg = 2'b00;
      if (mg == 1) begin
        eg = 2'b01; ecs = i_cs; ewe = i_we; eaddr = i_addr; edata = i_wdata; eia = mem_ack;
      end else if (mg == 2) begin
        eg = 2'b10; ecs = d_cs; ewe = d_we; eaddr = d_addr; edata = d_wdata; eda = mem_ack;
      end
      if (!rst) begin ecs = 1'b0; ewe = 1'b0; eia = 1'b0; eda = 1'b0; end
      chk("grant", grant, eg);
      chk("mem_cs", mem_cs, ecs);
      chk("mem_we", mem_we, ewe);
      chk("mem_addr", mem_addr, eaddr);
      chk("mem_wdata", mem_wdata, edata);
      chk("i_ack", i_ack, eia);
      chk("d_ack", d_ack, eda);
      chk("i_rdata", i_rdata, mem_rdata);
      chk("d_rdata", d_rdata, mem_rdata);
      chk("i_cnt", i_cnt, ci[CW-1:0]);
      chk("d_cnt", d_cnt, cd[CW-1:0]);
      if (prev_grant != 2'b00 && grant != 2'b00)
        chk("no_direct_handover", grant, prev_grant);
      prev_grant = grant;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; i_cs = 1'b0; d_cs = 1'b0; mem_ack = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
  endtask

  // n acks, one every 2 cycles, to whoever holds the grant.
  task automatic burst(input int n);
    for (int k = 0; k < n; k++) begin
      mem_ack = 1'b0; tick();
      mem_ack = 1'b1; mem_rdata = $urandom; tick();
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    logic [1:0] order_exp [6];
    logic [1:0] order_got [6];
    rst = 1'b0; i_cs = 1'b0; i_we = 1'b0; d_cs = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; i_wdata = '0; d_wdata = '0; mem_rdata = '0;

    // Reset then idle
    do_reset();
    chk("rst_grant", grant, 2'b00);
    chk("rst_mem_cs", mem_cs, 1'b0);
    chk("rst_i_cnt", i_cnt, 3'd0);
    chk("rst_d_cnt", d_cnt, 3'd0);
    $display("txn reset_idle grant=%b", grant);

    // Single I read burst
    i_cs = 1'b1; i_we = 1'b0; i_addr = 32'h0000_1000; i_wdata = 32'h1234_5678;
    tick();
    chk("iburst_grant", grant, 2'b01);
    chk("iburst_addr", mem_addr, 32'h0000_1000);
    burst(4);
    chk("iburst_i_cnt", i_cnt, 3'd4);
    chk("iburst_d_cnt", d_cnt, 3'd0);
    i_cs = 1'b0; tick();
    chk("iburst_release", grant, 2'b00);
    $display("txn i_burst i_cnt=%0d", i_cnt);

    // Simultaneous requests (last winner I -> D first in both builds)
    do_reset();
    i_cs = 1'b1; d_cs = 1'b1; d_addr = 32'h0000_2000; d_we = 1'b1;
    tick();
    chk("tie_first_grant", grant, 2'b10);
    burst(4);
    d_cs = 1'b0; tick();
    chk("tie_gap_grant", grant, 2'b00);
    chk("tie_gap_cs", mem_cs, 1'b0);
    tick();
    chk("tie_second_grant", grant, 2'b01);
    burst(4);
    i_cs = 1'b0; tick();
    chk("tie_i_cnt", i_cnt, 3'd4);
    chk("tie_d_cnt", d_cnt, 3'd4);
    $display("txn tie i_cnt=%0d d_cnt=%0d", i_cnt, d_cnt);

    // Tie after a D-only grant: round-robin favours I, fixed priority favours D
    do_reset();
    d_cs = 1'b1; tick(); burst(1); d_cs = 1'b0; tick();
    i_cs = 1'b1; d_cs = 1'b1; tick();
    chk("tie_after_d", grant, RR ? 2'b01 : 2'b10);
    i_cs = 1'b0; d_cs = 1'b0; tick();
    $display("txn tie_after_d rr=%0d", RR);

    // Three tie rounds
    do_reset();
    for (int r = 0; r < 3; r++) begin
      order_exp[2*r] = 2'b10; order_exp[2*r+1] = 2'b01;
      i_cs = 1'b1; d_cs = 1'b1; tick();
      order_got[2*r] = grant;
      burst(1);
      if (grant == 2'b01) i_cs = 1'b0; else d_cs = 1'b0;
      tick(); tick();
      order_got[2*r+1] = grant;
      burst(1);
      i_cs = 1'b0; d_cs = 1'b0; tick();
    end
    for (int r = 0; r < 6; r++) chk("rr_order", order_got[r], order_exp[r]);
    $display("txn rr_rounds %b %b %b %b %b %b", order_got[0], order_got[1], order_got[2],
             order_got[3], order_got[4], order_got[5]);

    // No pre-emption over 8 acks; D counter saturates at 7
    do_reset();
    d_cs = 1'b1; i_cs = 1'b1; tick();
    for (int k = 0; k < 8; k++) begin
      mem_ack = 1'b0; tick();
      mem_ack = 1'b1; tick();
      chk("nopre_grant", grant, 2'b10);
      chk("nopre_i_ack", i_ack, 1'b0);
    end
    mem_ack = 1'b0;
    chk("nopre_d_sat", d_cnt, 3'd7);
    d_cs = 1'b0; tick();
    chk("nopre_gap", grant, 2'b00);
    tick();
    chk("nopre_then_i", grant, 2'b01);
    i_cs = 1'b0; tick();
    $display("txn no_preempt d_cnt=%0d", d_cnt);

    // Reset mid-grant, then a stray ack in IDLE
    do_reset();
    i_cs = 1'b1; tick(); burst(2);
    rst = 1'b0; tick();
    chk("midrst_grant", grant, 2'b00);
    chk("midrst_cs", mem_cs, 1'b0);
    chk("midrst_i_cnt", i_cnt, 3'd0);
    rst = 1'b1; i_cs = 1'b0; mem_ack = 1'b1; tick();
    chk("stray_i_ack", i_ack, 1'b0);
    chk("stray_d_ack", d_ack, 1'b0);
    mem_ack = 1'b0; tick();
    chk("stray_i_cnt", i_cnt, 3'd0);
    $display("txn mid_reset grant=%b i_cnt=%0d", grant, i_cnt);

    // Random traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) i_cs = ~i_cs;
      if ($urandom_range(0, 7) == 0) d_cs = ~d_cs;
      i_we = 1'($urandom); d_we = 1'($urandom);
      i_addr = $urandom; d_addr = $urandom;
      i_wdata = $urandom; d_wdata = $urandom;
      mem_ack = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      tick();
    end
    $display("txn random cycles=3000");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
